uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 RX_IN  input  1  serial line; idle high; synchronous to clk.
REQ-005 prescale  input  6  clk cycles per bit; legal values 8, 16, 32.
REQ-006 par_en  input  1  1 = parity bit present in frame.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-009 data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 stp_err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-012 Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity bit, stop(1).
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START in the cycle RX_IN is sampled 0; that cycle is edge count 0 of the start bit.
REQ-015 Edge counter counts 0..prescale-1 per bit and wraps to 0 at each bit boundary.
REQ-016 Bit counter counts data bits 0..DATA_WIDTH-1 in DATA.
REQ-017 Bit value is sampled at edge count prescale/2 (see REQ-031).
REQ-018 START: a sampled 1 is a glitch -> IDLE at the end of the bit; no outputs pulse.
REQ-019 START -> DATA at the start-bit wrap; DATA -> PARITY (par_en=1) or STOP (par_en=0) after the last data bit.
REQ-020 Parity: even expected = XOR of data; odd expected = XNOR of data.
REQ-021 prescale, par_en and par_typ are latched on IDLE->START and held for the whole frame.
REQ-022 Illegal prescale latched (not 8/16/32) -> operation as prescale 8.
REQ-023 At the last edge count of STOP, exactly one outcome occurs:
  - data_valid=1 and P_DATA loaded, if the stop bit is 1 and there is no parity error;
  - otherwise par_err and/or stp_err=1 and P_DATA unchanged.
REQ-024 The outcome pulse occurs (1+DATA_WIDTH+par_en+1)*prescale-1 cycles after the start-detect cycle.
REQ-025 STOP -> IDLE after the last edge count; a 0 on RX_IN in the next cycle starts a new frame (back-to-back frames).
REQ-026 P_DATA holds its value between frames and is never driven from the partial shift register.
REQ-027 par_err and stp_err can pulse in the same cycle.

Reset
REQ-028 rstn=0 asynchronously forces FSM=IDLE, counters=0, shift register=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0.
REQ-029 Reset mid-frame discards the partial frame; after rstn rises, the receiver waits in IDLE for a new falling edge with no pulses.
REQ-030 While RX_IN is held 0 from reset release, the receiver treats the line as a start bit; no special handling is required.

Configuration
REQ-031 Macro UART_RX_MAJORITY_EN:
  - defined: each bit value is the 2-of-3 majority of samples at edge counts prescale/2-1, prescale/2 and prescale/2+1;
  - undefined: single sample at edge count prescale/2.
  Timing of all outputs is identical in both builds.

Verification
REQ-032 prescale=8, par_en=1, par_typ=0, byte 0x9C (parity 0) -> data_valid pulse at cycle 87 after start detect, P_DATA=0x9C, no error pulses.
REQ-033 prescale=16, par_en=1, par_typ=1, byte 0x9C with parity bit 0 (wrong; correct odd parity is 1) -> par_err pulse, data_valid=0, P_DATA keeps its previous value.
REQ-034 prescale=32, par_en=0, byte 0xC3, stop bit driven 0 -> stp_err pulse at cycle 319, data_valid=0.
REQ-035 Back-to-back frames 0xA5 then 0x5A, prescale=8, par_en=0, no idle gap -> two data_valid pulses 80 cycles apart, P_DATA=0xA5 then 0x5A.
REQ-036 Low glitch of 2 cycles on an idle line, prescale=8 -> return to IDLE and no pulses. In the UART_RX_MAJORITY_EN build, a 1-cycle spike inverted at mid-bit of data bit 3 -> byte still received correctly.
REQ-037 rstn pulsed low during data bit 4 -> all outputs 0 immediately; the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// prescale / par_en / par_typ are captured at start detect and held per frame;
// an illegal prescale (not 8/16/32) runs as 8.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// the samples at prescale/2-1, prescale/2 and prescale/2+1 instead of a single
// sample at prescale/2. Output timing is the same in both builds.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  bit_val_q, bit_val_d;
  logic                  par_bit_q, par_bit_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic [5:0] half;
  logic [5:0] last;
  logic       bit_end;
  logic       par_exp;
  logic       par_bad;

  assign half    = {1'b0, presc_q[5:1]};
  assign last    = presc_q - 6'd1;
  assign bit_end = (edge_cnt_q == last);
  // Even parity expects XOR of the data; odd parity expects its complement.
  assign par_exp = (^shift_q) ^ par_typ_q;
  assign par_bad = par_en_q && (par_bit_q != par_exp);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  // Bit sampler: collect two early samples, resolve the majority on the third.
  always_comb begin
    maj_d     = maj_q;
    bit_val_d = bit_val_q;
    if (state_q != IDLE) begin
      if (edge_cnt_q == half - 6'd1) maj_d[0] = RX_IN;
      if (edge_cnt_q == half)        maj_d[1] = RX_IN;
      if (edge_cnt_q == half + 6'd1) begin
        bit_val_d = (maj_q[0] & maj_q[1]) | (maj_q[0] & RX_IN) | (maj_q[1] & RX_IN);
      end
    end
  end

  // Majority sample holding register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) maj_q <= '0;
    else       maj_q <= maj_d;
  end
`else
  // Bit sampler: single sample at mid-bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    bit_val_d = bit_val_q;
    if (state_q != IDLE && edge_cnt_q == half) bit_val_d = RX_IN;
  end
`endif

  // Next-state, counters, shift register and outcome pulses.
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bit_d    = par_bit_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != IDLE) edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;

    unique case (state_q)
      IDLE: begin
        // The detect cycle itself is edge count 0, so the counter resumes at 1.
        if (!RX_IN) begin
          state_d    = START;
          edge_cnt_d = 6'd1;
          bit_cnt_d  = '0;
          presc_d    = (prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32)
                       ? prescale : 6'd8;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
        end
      end
      START: begin
        // A high mid-bit sample means the falling edge was a glitch.
        if (bit_end) state_d = bit_val_q ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = bit_val_q;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_bit_d = bit_val_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (!bit_val_q || par_bad) begin
            par_err_d = par_bad;
            stp_err_d = !bit_val_q;
          end else begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      bit_val_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values.
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      bit_val_q    <= bit_val_d;
      par_bit_q    <= par_bit_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames for uart_rx, checked against a
// frame-level reference model (bit list, parity by counting ones, latency by
// frame length times effective prescale).
module tb_uart_rx;

  logic       clk;
  logic       rstn;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int         n_checks;
  int         n_err;
  logic [7:0] exp_pdata;
  int         cyc;
  int         last_dv_cyc;
  int         last_ev_k;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .RX_IN      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for measuring pulse spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the run ever overruns.
  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout, expected summary before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the line idle and require silence on every output pulse.
  task automatic idle_cycles(input int n, input string tag);
    int pulses;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_in = 1'b1;
      @(posedge clk);
      #1;
      if (data_valid || par_err || stp_err) pulses++;
    end
    check({tag, "/no_pulse"}, pulses, 0);
  endtask

  // Drive one frame starting at the next negedge and check its single outcome.
  task automatic run_frame(input logic [7:0] data, input logic [5:0] p_in,
                           input logic pen, input logic ptyp, input logic par_flip,
                           input logic stop_bit, input int spike_cyc,
                           input logic scramble, input string tag);
    int   pe;
    int   ncyc;
    int   ones;
    int   dv_cnt;
    int   pe_cnt;
    int   se_cnt;
    int   ev_at;
    logic good_par;
    logic exp_dv;
    logic exp_pe;
    logic exp_se;
    logic bits[$];

    pe       = (p_in == 6'd8 || p_in == 6'd16 || p_in == 6'd32) ? int'(p_in) : 8;
    ones     = 0;
    for (int i = 0; i < 8; i++) if (data[i]) ones++;
    good_par = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);

    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pen) bits.push_back(good_par ^ par_flip);
    bits.push_back(stop_bit);
    ncyc = bits.size() * pe;

    exp_pe = pen && par_flip;
    exp_se = !stop_bit;
    exp_dv = !exp_pe && !exp_se;

    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; ev_at = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      rx_in = bits[k / pe] ^ (k == spike_cyc);
      if (k == 0) begin
        prescale = p_in;
        par_en   = pen;
        par_typ  = ptyp;
      end else if (k == 1 && scramble) begin
        prescale = 6'($urandom_range(0, 63));
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (data_valid) begin dv_cnt++; last_dv_cyc = cyc; end
      if (par_err) pe_cnt++;
      if (stp_err) se_cnt++;
      if ((data_valid || par_err || stp_err) && ev_at < 0) ev_at = k;
    end
    last_ev_k = ev_at;
    if (exp_dv) exp_pdata = data;

    check({tag, "/data_valid"}, dv_cnt, {31'd0, exp_dv});
    check({tag, "/par_err"},    pe_cnt, {31'd0, exp_pe});
    check({tag, "/stp_err"},    se_cnt, {31'd0, exp_se});
    check({tag, "/latency"},    ev_at,  ncyc - 1);
    check({tag, "/P_DATA"},     p_data, exp_pdata);
  endtask

  initial begin
    int   prev_dv;
    int   pulses;
    logic [7:0] part;
    logic [5:0] rp;

    n_checks = 0; n_err = 0; exp_pdata = 8'h00; cyc = 0;
    last_dv_cyc = 0; last_ev_k = -1;
    rstn = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset/P_DATA", p_data, 0);
    check("reset/data_valid", data_valid, 0);
    check("reset/par_err", par_err, 0);
    check("reset/stp_err", stp_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    idle_cycles(10, "post_reset");

    // Good even-parity byte at prescale 8; outcome 87 cycles after detect.
    run_frame(8'h9C, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, "p8_even");
    check("p8_even/cycle87", last_ev_k, 87);
    idle_cycles(3, "gap1");

    // Change P_DATA so the parity-error frame has something to preserve.
    run_frame(8'h11, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, "p16_plain");

    // Wrong odd parity at prescale 16.
    run_frame(8'h9C, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, "p16_odd_bad");
    idle_cycles(2, "gap2");

    // Stop bit low at prescale 32; outcome 319 cycles after detect.
    run_frame(8'hC3, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, "p32_stop0");
    check("p32_stop0/cycle319", last_ev_k, 319);
    idle_cycles(2, "gap3");

    // Back-to-back frames with no idle gap.
    run_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, "b2b_a5");
    prev_dv = last_dv_cyc;
    run_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, "b2b_5a");
    check("b2b/spacing", last_dv_cyc - prev_dv, 80);

    // Two-cycle low glitch on an idle line at prescale 8.
    prescale = 6'd8;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rx_in = (k < 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (data_valid || par_err || stp_err) pulses++;
    end
    check("glitch/no_pulse", pulses, 0);
    check("glitch/P_DATA", p_data, exp_pdata);
    run_frame(8'h66, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, "after_glitch");

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted spike at mid-bit of data bit 3 (frame bit 4).
    run_frame(8'hB2, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 16 + 8, 1'b0, "maj_spike");
`endif

    // Reset asserted during data bit 4 of a frame.
    part = 8'hE7;
    prescale = 6'd8; par_en = 1'b0;
    for (int k = 0; k < 5 * 8 + 4; k++) begin
      @(negedge clk);
      rx_in = (k < 8) ? 1'b0 : part[k / 8 - 1];
    end
    #2;
    rstn = 1'b0;
    #1;
    exp_pdata = 8'h00;
    check("midreset/P_DATA", p_data, 0);
    check("midreset/data_valid", data_valid, 0);
    check("midreset/par_err", par_err, 0);
    check("midreset/stp_err", stp_err, 0);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle_cycles(40, "midreset_idle");
    run_frame(8'h3C, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, "after_reset");

    // Randomized frames, config inputs scrambled after start detect.
    for (int f = 0; f < 14; f++) begin
      case ($urandom_range(0, 3))
        0:       rp = 6'd8;
        1:       rp = 6'd16;
        2:       rp = 6'd32;
        default: begin
          rp = 6'($urandom_range(0, 63));
          while (rp == 6'd8 || rp == 6'd16 || rp == 6'd32) rp = 6'($urandom_range(0, 63));
        end
      endcase
      run_frame(8'($urandom), rp, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                -1, 1'b1, $sformatf("rand%0d", f));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)), $sformatf("rgap%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
